sdram_stream_reader: RTL



---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_stream_reader_if.sv | 29 ++
 rtl/sdram_stream_fifo.sv | 59 +++++
 rtl/sdram_stream_reader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM stream blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;

  typedef logic [SDRAM_ADDR_W-1:0] sdram_addr_t;
  typedef logic [SDRAM_DATA_W-1:0] sdram_data_t;

  // ABORTING is only reachable when the abort feature is compiled in.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    DRAIN    = 2'd2,
    ABORTING = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sdram_stream_reader_if.sv
// Controller request/response channels plus the outgoing word stream.
// Latency: n/a (wiring only).
// Backpressure: aready stalls requests, oready stalls the stream; bvalid cannot stall.
interface sdram_stream_reader_if;
  import sdram_pkg::*;

  logic        avalid;
  logic        awe;
  sdram_addr_t aaddr;
  logic        aready;
  logic        bvalid;
  sdram_data_t bdata;
  logic        ovalid;
  logic        oready;
  sdram_data_t odata;

  // Reader side: drives requests and the output stream.
  modport master (
    output avalid, awe, aaddr, ovalid, odata,
    input  aready, bvalid, bdata, oready
  );

  // Controller / sink side.
  modport slave (
    input  avalid, awe, aaddr, ovalid, odata,
    output aready, bvalid, bdata, oready
  );

endinterface

// File: rtl/sdram_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees the slot that cycle.
module sdram_stream_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rptr];

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr] <= wr_dat;
    end
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_stream_reader.sv
// Reads a linear word range from the SDRAM controller and streams it out in order.
// Latency: first request 1 cycle after start, first ovalid 1 cycle after first bvalid.
// Backpressure: oready stalls the FIFO; credits cap outstanding+buffered at FIFO_DEPTH.
// Optional abort input enabled by SDRAM_STREAM_READER_ABORT_EN.
module sdram_stream_reader
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  sdram_addr_t        base_addr,
  input  logic [CNT_W-1:0]   length,
`ifdef SDRAM_STREAM_READER_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  sdram_stream_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t        state_q, state_d;
  sdram_addr_t      base_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] deliv_q, deliv_d;
  logic [CW-1:0]    out_q, out_d;
  logic             avalid_q, avalid_d;
  logic             done_q, done_d;
  logic             load;

  logic             abort_req;
  logic             acc;
  logic             beat;
  logic             push;
  logic             pop;
  logic             flush;
  logic             in_xfer;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    cnt_d;
  logic [CW:0]      credit_sum;
  logic             credit_ok;
  logic             fifo_empty;
  logic             fifo_full;
  sdram_data_t      fifo_dat;

`ifdef SDRAM_STREAM_READER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_xfer = (state_q == ISSUE) || (state_q == DRAIN);
  assign acc     = avalid_q && bus.aready;
  // Beats are still counted against outstanding while aborting, just not stored.
  assign beat    = bus.bvalid && (out_q != '0) && (state_q != IDLE);
  assign push    = bus.bvalid && in_xfer;
  assign flush   = (state_q == ABORTING);
  assign pop     = bus.ovalid && bus.oready;

  // Next-cycle occupancy; the credit check uses these so a request raised now
  // always has a slot reserved for its response.
  assign out_d      = out_q + CW'(acc) - CW'(beat);
  assign cnt_d      = fifo_count + CW'(push) - CW'(pop);
  assign credit_sum = {1'b0, out_d} + {1'b0, cnt_d};
  assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign bus.avalid = avalid_q;
  assign bus.awe    = 1'b0;
  assign bus.aaddr  = avalid_q ? (base_q + sdram_addr_t'(issued_q)) : '0;
  assign bus.ovalid = !fifo_empty && (state_q != ABORTING);
  assign bus.odata  = fifo_dat;

  // Next-state, request and counter decisions.
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q + CNT_W'(acc);
    deliv_d  = deliv_q + CNT_W'(pop);
    avalid_d = avalid_q && !bus.aready;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            load     = 1'b1;
            state_d  = ISSUE;
            avalid_d = 1'b1;
            issued_d = '0;
            deliv_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort_req) begin
          state_d = ABORTING;
        end else if (issued_d == len_q) begin
          state_d = DRAIN;
        end else if (!avalid_d && credit_ok) begin
          avalid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (abort_req) begin
          state_d = ABORTING;
        end else if ((deliv_d == len_q) && (out_d == '0) && (cnt_d == '0)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORTING: begin
        if ((out_d == '0) && !avalid_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      deliv_q  <= '0;
      out_q    <= '0;
      avalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      deliv_q  <= deliv_d;
      out_q    <= out_d;
      avalid_q <= avalid_d;
      done_q   <= done_d;
      if (load) begin
        base_q <= base_addr;
        len_q  <= length;
      end
    end
  end

  sdram_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SDRAM_DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (bus.bdata),
    .pop    (pop),
    .flush  (flush),
    .rd_dat (fifo_dat),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // The credit scheme guarantees a free slot for every response beat.
  a_no_beat_on_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
